nec_ir_tx: RTL

NEC_IR_TX -- requirements
Module: nec_ir_tx

---
 rtl/nec_ir_pkg.sv | 32 +++
 rtl/nec_ir_carrier.sv | 37 +++
 rtl/nec_ir_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nec_ir_pkg.sv
`default_nettype none
// ============================================================================
// nec_ir_pkg : state encoding and NEC frame timing constants (in units)
// Rev 1.0
// ============================================================================
package nec_ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4,
        ST_STOP_MARK  = 3'd5,
        ST_GAP        = 3'd6
    } state_t;

    localparam int LEAD_MARK  = 16;
    localparam int LEAD_SPACE = 8;
    localparam int REP_SPACE  = 4;
    localparam int BIT_MARK   = 1;
    localparam int ZERO_SPACE = 1;
    localparam int ONE_SPACE  = 3;
    localparam int STOP       = 1;
    localparam int NBITS      = 32;

    function automatic logic is_mark(input state_t s);
        return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nec_ir_carrier.sv
`default_nettype none
// ============================================================================
// nec_ir_carrier : square-wave carrier, high first, phase restarts when en rises
// Rev 1.0
// ============================================================================
module nec_ir_carrier #(
    parameter int CARRIER_HALF = 658
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic carrier
);

    localparam int c_HW = $clog2(CARRIER_HALF + 1);
    localparam logic [c_HW-1:0] c_HALF_LAST = c_HW'(CARRIER_HALF - 1);

    logic [c_HW-1:0] r_cnt;
    logic            r_phase;

    // Held at the start phase while disabled, so every enable begins high.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == c_HALF_LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign carrier = en & r_phase;

endmodule
`default_nettype wire

// File: rtl/nec_ir_tx.sv
`default_nettype none
// ============================================================================
// nec_ir_tx : NEC infrared frame transmitter (data and repeat frames)
// Rev 1.0
// ============================================================================
module nec_ir_tx
    import nec_ir_pkg::*;
#(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int GAP_UNITS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_repeat,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       ir_out,
    output logic       ir_env,
    output logic       done
);

    localparam int c_MAX_UNITS = (GAP_UNITS > LEAD_MARK) ? GAP_UNITS : LEAD_MARK;
    localparam int c_CW        = $clog2(UNIT_CYCLES + 1);
    localparam int c_UW        = $clog2(c_MAX_UNITS + 1);
    localparam logic [c_CW-1:0] c_CYC_LAST = c_CW'(UNIT_CYCLES - 1);
    localparam logic [4:0]      c_BIT_LAST = 5'(NBITS - 1);

    state_t          r_state, w_next;
    logic [c_CW-1:0] r_cyc;
    logic [c_UW-1:0] r_units, w_dur;
    logic [4:0]      r_bit;
    logic [31:0]     r_data;
    logic            r_rep, r_ready;
    logic            w_accept, w_unit_end, w_state_end, w_env, w_carrier;

    assign w_accept    = cmd_valid & r_ready;
    assign w_unit_end  = (r_cyc == c_CYC_LAST);
    assign w_state_end = w_unit_end && (r_units == w_dur - 1'b1);

    always_comb begin
        w_dur = c_UW'(1);
        case (r_state)
            ST_LEAD_MARK:  w_dur = c_UW'(LEAD_MARK);
            ST_LEAD_SPACE: w_dur = r_rep ? c_UW'(REP_SPACE) : c_UW'(LEAD_SPACE);
            ST_BIT_MARK:   w_dur = c_UW'(BIT_MARK);
            ST_BIT_SPACE:  w_dur = r_data[0] ? c_UW'(ONE_SPACE) : c_UW'(ZERO_SPACE);
            ST_STOP_MARK:  w_dur = c_UW'(STOP);
            ST_GAP:        w_dur = c_UW'(GAP_UNITS);
            default:       w_dur = c_UW'(1);
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_accept)    w_next = ST_LEAD_MARK;
            ST_LEAD_MARK:  if (w_state_end) w_next = ST_LEAD_SPACE;
            ST_LEAD_SPACE: if (w_state_end) w_next = r_rep ? ST_STOP_MARK : ST_BIT_MARK;
            ST_BIT_MARK:   if (w_state_end) w_next = ST_BIT_SPACE;
            ST_BIT_SPACE:  if (w_state_end) w_next = (r_bit == c_BIT_LAST) ? ST_STOP_MARK
                                                                          : ST_BIT_MARK;
            ST_STOP_MARK:  if (w_state_end) w_next = ST_GAP;
            ST_GAP:        if (w_state_end) w_next = ST_IDLE;
            default:                        w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_cyc   <= '0;
            r_units <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_rep   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == ST_IDLE);
            if (r_state == ST_IDLE) begin
                r_cyc   <= '0;
                r_units <= '0;
                r_bit   <= '0;
                if (w_accept) begin
                    r_data <= {~cmd, cmd, ~addr, addr};
                    r_rep  <= cmd_repeat;
                end
            end else begin
                r_cyc <= w_unit_end ? '0 : r_cyc + 1'b1;
                if (w_state_end)
                    r_units <= '0;
                else if (w_unit_end)
                    r_units <= r_units + 1'b1;
                // Payload shifts out LSB first; bit index tracks the 32-bit boundary.
                if (r_state == ST_BIT_SPACE && w_state_end) begin
                    r_data <= r_data >> 1;
                    r_bit  <= (r_bit == c_BIT_LAST) ? '0 : r_bit + 1'b1;
                end
            end
        end
    end

    assign w_env = is_mark(r_state) & ~reset;

    nec_ir_carrier #(
        .CARRIER_HALF(CARRIER_HALF)
    ) u_carrier (
        .clk    (clk),
        .reset  (reset),
        .en     (w_env),
        .carrier(w_carrier)
    );

    assign ir_env    = w_env;
    assign ir_out    = w_env & w_carrier;
    assign done      = (r_state == ST_GAP) && w_state_end && !reset;
    assign cmd_ready = r_ready & ~reset;

endmodule
`default_nettype wire
